silife_load_master: RTL and testbench

- Host-side transmitter for the serial cell-load chain that feeds silife tiles: serializes bytes onto the load_cs/load_clk/load_data lines the tiles receive.
- Simultaneously captures the data returning from the far end of the daisy-chain for readback, like a full-duplex SPI master.
- Sits between the host register interface / SoC bus glue and the silife tile array, in the same core clock domain.

---
 rtl/silife_pkg.sv | 16 +
 rtl/silife_load_master.sv | 187 ++++++++++++++++++
 tb/tb_silife_load_master.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/silife_pkg.sv
// Shared types and load-chain polarity constants for the silife host-side blocks.
package silife_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    STALL,
    HOLD,
    GAP
  } state_e;

  localparam logic LOAD_CS_ACTIVE = 1'b1;
  localparam logic LOAD_CLK_IDLE  = 1'b0;

endpackage

// File: rtl/silife_load_master.sv
// Full-duplex serial master for the silife cell-load chain: shifts words out MSB first
// on load_cs/load_clk/load_data and assembles the word returning from the chain end.
module silife_load_master
  import silife_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned WORD_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WORD_W-1:0] i_data,
  input  logic              i_last,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_abort,
  output logic              o_load_cs,
  output logic              o_load_clk,
  output logic              o_load_data,
  input  logic              i_load_data_ret,
  output logic [WORD_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  output logic              o_busy
);

  localparam int unsigned      BIT_W      = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [7:0]       PHASE_LAST = 8'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(WORD_W - 1);

  state_e              state_q, state_d;
  logic [7:0]          phase_q, phase_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [WORD_W-1:0]   tx_q, tx_d;
  logic                tx_last_q, tx_last_d;
  logic [WORD_W-1:0]   rx_sh_q, rx_sh_d;
  logic [WORD_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                buf_full_q, buf_full_d;
  logic [WORD_W-1:0]   buf_data_q, buf_data_d;
  logic                buf_last_q, buf_last_d;
  logic                cs_q, cs_d;
  logic                lclk_q, lclk_d;
  logic                ldata_q, ldata_d;

  logic phase_done;
  logic accept;
  logic load;
  logic frame_active;

  assign phase_done = (phase_q == PHASE_LAST);
  assign accept     = i_valid && !buf_full_q && !i_abort;

  // State register (all flops, including the output registers).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      bit_q      <= '0;
      tx_q       <= '0;
      tx_last_q  <= 1'b0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      buf_full_q <= 1'b0;
      buf_data_q <= '0;
      buf_last_q <= 1'b0;
      cs_q       <= ~LOAD_CS_ACTIVE;
      lclk_q     <= LOAD_CLK_IDLE;
      ldata_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      tx_q       <= tx_d;
      tx_last_q  <= tx_last_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      buf_full_q <= buf_full_d;
      buf_data_q <= buf_data_d;
      buf_last_q <= buf_last_d;
      cs_q       <= cs_d;
      lclk_q     <= lclk_d;
      ldata_q    <= ldata_d;
    end
  end

  // Next-state and datapath.
  always_comb begin
    // NOTE: defaults first on every path, otherwise holding values infers latches.
    state_d    = state_q;
    phase_d    = phase_q;
    bit_d      = bit_q;
    tx_d       = tx_q;
    tx_last_d  = tx_last_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    buf_full_d = buf_full_q;
    buf_data_d = buf_data_q;
    buf_last_d = buf_last_q;
    load       = 1'b0;

    unique case (state_q)
      IDLE, STALL: load = buf_full_q;
      SHIFT_LO: begin
        if (phase_done) begin
          state_d = SHIFT_HI;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      SHIFT_HI: begin
        if (phase_q == '0) rx_sh_d = (rx_sh_q << 1) | WORD_W'(i_load_data_ret);
        if (phase_done) begin
          phase_d = '0;
          if (bit_q != BIT_LAST) begin
            bit_d   = bit_q + 1'b1;
            tx_d    = tx_q << 1;
            state_d = SHIFT_LO;
          end else begin
            rx_valid_d = 1'b1;
            rx_data_d  = rx_sh_d;
            // Word boundary costs no cycle: the decision is folded into this edge.
            if (tx_last_q)       state_d = HOLD;
            else if (buf_full_q) load    = 1'b1;
            else                 state_d = STALL;
          end
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      HOLD, GAP: begin
        if (phase_done) begin
          state_d = (state_q == HOLD) ? GAP : IDLE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      tx_d       = buf_data_q;
      tx_last_d  = buf_last_q;
      bit_d      = '0;
      phase_d    = '0;
      state_d    = SHIFT_LO;
      buf_full_d = 1'b0;
    end

    if (accept) begin
      buf_full_d = 1'b1;
      buf_data_d = i_data;
      buf_last_d = i_last;
    end

    // Abort wins over everything but reset; a partial word never reaches o_rx_data.
    if (i_abort) begin
      state_d    = GAP;
      phase_d    = '0;
      bit_d      = '0;
      buf_full_d = 1'b0;
      rx_valid_d = 1'b0;
      rx_data_d  = rx_data_q;
    end
  end

  // Output decode, registered so the chain lines are glitch-free.
  always_comb begin
    frame_active = state_d inside {SHIFT_LO, SHIFT_HI, STALL, HOLD};
    cs_d         = frame_active ? LOAD_CS_ACTIVE : ~LOAD_CS_ACTIVE;
    lclk_d       = (state_d == SHIFT_HI) ? ~LOAD_CLK_IDLE : LOAD_CLK_IDLE;
    ldata_d      = frame_active & tx_d[WORD_W-1];
  end

  assign o_load_cs   = cs_q;
  assign o_load_clk  = lclk_q;
  assign o_load_data = ldata_q;
  assign o_rx_data   = rx_data_q;
  assign o_rx_valid  = rx_valid_q;
  assign o_ready     = !buf_full_q;
  assign o_busy      = (state_q != IDLE) || buf_full_q;

endmodule

// File: tb/tb_silife_load_master.sv
// Directed bench for silife_load_master in loopback; rx words are scoreboarded against sent words.
module tb_silife_load_master;

  localparam int CLK_DIV = 2;
  localparam int WORD_W  = 8;
  localparam int BIT_CYC = 2 * CLK_DIV;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [WORD_W-1:0] i_data = '0;
  logic              i_last = 1'b0;
  logic              i_valid = 1'b0;
  logic              i_abort = 1'b0;
  logic              o_ready;
  logic              o_load_cs;
  logic              o_load_clk;
  logic              o_load_data;
  logic              load_data_ret;
  logic [WORD_W-1:0] o_rx_data;
  logic              o_rx_valid;
  logic              o_busy;

  assign load_data_ret = o_load_data;

  silife_load_master #(.CLK_DIV(CLK_DIV), .WORD_W(WORD_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_data         (i_data),
    .i_last         (i_last),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_abort        (i_abort),
    .o_load_cs      (o_load_cs),
    .o_load_clk     (o_load_clk),
    .o_load_data    (o_load_data),
    .i_load_data_ret(load_data_ret),
    .o_rx_data      (o_rx_data),
    .o_rx_valid     (o_rx_valid),
    .o_busy         (o_busy)
  );

  always #5 clk = ~clk;

  // Line monitor, sampled on the falling edge.
  int          cyc = 0;
  int          edges = 0;
  int          cs_cycles = 0;
  int          cs_rises = 0;
  int          irregular = 0;
  int          last_edge_cyc = 0;
  int          frame_edges = 0;
  logic        prev_clk = 1'b0;
  logic        prev_cs = 1'b0;
  logic        edge_bits[$];
  logic [7:0]  rx_got[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (o_load_cs) cs_cycles <= cs_cycles + 1;
    if (o_load_cs && !prev_cs) cs_rises <= cs_rises + 1;
    if (!o_load_cs) frame_edges <= 0;
    if (o_load_clk && !prev_clk) begin
      edges <= edges + 1;
      edge_bits.push_back(o_load_data);
      if (frame_edges > 0 && cyc - last_edge_cyc != BIT_CYC) irregular <= irregular + 1;
      last_edge_cyc <= cyc;
      frame_edges   <= frame_edges + 1;
    end
    if (o_rx_valid) rx_got.push_back(o_rx_data);
    prev_clk <= o_load_clk;
    prev_cs  <= o_load_cs;
  end

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  int         rx_rd = 0;
  int         e0, c0, cr0, ir0, b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    e0  = edges;
    c0  = cs_cycles;
    cr0 = cs_rises;
    ir0 = irregular;
    b0  = edge_bits.size();
  endtask

  function automatic int bits_word(input int base);
    int w = 0;
    for (int i = base; i < edge_bits.size(); i++) w = (w << 1) | int'(edge_bits[i]);
    return w;
  endfunction

  task automatic send(input logic [7:0] d, input logic last, input bit expect_rx);
    int n = 0;
    i_data  = d;
    i_last  = last;
    i_valid = 1'b1;
    while (!o_ready && n < 200) begin
      tick();
      n++;
    end
    check("send_ready", 32'(o_ready), 1);
    tick();
    i_valid = 1'b0;
    if (expect_rx) exp_q.push_back(d);
  endtask

  task automatic wait_idle(output int gap);
    int n = 0;
    bit seen = 1'b0;
    gap = 0;
    while (o_busy && n < 400) begin
      tick();
      n++;
      if (o_load_cs) seen = 1'b1;
      else if (seen && o_busy) gap++;
    end
    check("idle_wait", 32'(o_busy), 0);
  endtask

  task automatic wait_edges(input int target);
    int n = 0;
    while (edges - e0 < target && n < 400) begin
      tick();
      n++;
    end
    check("edge_wait", edges - e0, target);
  endtask

  task automatic sb_drain();
    check("rx_count", rx_got.size() - rx_rd, exp_q.size());
    while (rx_rd < rx_got.size() && exp_q.size() > 0) begin
      check("rx_data", 32'(rx_got[rx_rd]), 32'(exp_q.pop_front()));
      rx_rd++;
    end
    exp_q.delete();
    rx_rd = rx_got.size();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cs"},       32'(o_load_cs),   0);
    check({tag, "_lclk"},     32'(o_load_clk),  0);
    check({tag, "_ldata"},    32'(o_load_data), 0);
    check({tag, "_rx_data"},  32'(o_rx_data),   0);
    check({tag, "_rx_valid"}, 32'(o_rx_valid),  0);
    check({tag, "_busy"},     32'(o_busy),      0);
    check({tag, "_ready"},    32'(o_ready),     1);
  endtask

  initial begin
    int gap;
    int stall_bad;

    // Reset state.
    repeat (3) tick();
    check_idle_outputs("reset");
    reset_n = 1'b1;
    tick();

    // Single word 0xA5, last.
    snap();
    send(8'hA5, 1'b1, 1'b1);
    wait_idle(gap);
    check("a5_cs_cycles", cs_cycles - c0, 34);
    check("a5_edges",     edges - e0, 8);
    check("a5_bits",      bits_word(b0), 'hA5);
    check("a5_frames",    cs_rises - cr0, 1);
    check("a5_gap_ge2",   32'(gap >= 2), 1);
    sb_drain();

    // Loopback readback of 0x3C.
    snap();
    send(8'h3C, 1'b1, 1'b1);
    wait_idle(gap);
    check("3c_edges", edges - e0, 8);
    sb_drain();

    // Back-to-back 0x12, 0x34(last).
    snap();
    send(8'h12, 1'b0, 1'b1);
    send(8'h34, 1'b1, 1'b1);
    check("b2b_ready_low", 32'(o_ready), 0);
    check("b2b_busy",      32'(o_busy),  1);
    wait_idle(gap);
    check("b2b_cs_cycles", cs_cycles - c0, 66);
    check("b2b_edges",     edges - e0, 16);
    check("b2b_bits",      bits_word(b0), 'h1234);
    check("b2b_irregular", irregular - ir0, 0);
    check("b2b_frames",    cs_rises - cr0, 1);
    sb_drain();

    // 0x55 non-last, stall 20 cycles, then 0xFF last.
    snap();
    send(8'h55, 1'b0, 1'b1);
    wait_edges(8);
    stall_bad = 0;
    repeat (20) begin
      tick();
      if (!(o_load_cs && !o_load_clk && o_load_data)) stall_bad++;
    end
    check("stall_lines", stall_bad, 0);
    send(8'hFF, 1'b1, 1'b1);
    wait_idle(gap);
    check("stall_edges",  edges - e0, 16);
    check("stall_bits",   bits_word(b0), 'h55FF);
    check("stall_frames", cs_rises - cr0, 1);
    sb_drain();

    // Abort after the third rising edge, with a word buffered and one offered.
    snap();
    send(8'hA5, 1'b1, 1'b0);
    send(8'h77, 1'b1, 1'b0);
    wait_edges(3);
    i_data  = 8'h99;
    i_valid = 1'b1;
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    i_valid = 1'b0;
    check("abort_cs",       32'(o_load_cs),   0);
    check("abort_lclk",     32'(o_load_clk),  0);
    check("abort_ldata",    32'(o_load_data), 0);
    check("abort_ready",    32'(o_ready),     1);
    check("abort_rx_valid", 32'(o_rx_valid),  0);
    wait_idle(gap);
    check("abort_edges", edges - e0, 3);
    sb_drain();

    snap();
    send(8'h01, 1'b1, 1'b1);
    wait_idle(gap);
    check("post_abort_cs_cycles", cs_cycles - c0, 34);
    check("post_abort_edges",     edges - e0, 8);
    check("post_abort_bits",      bits_word(b0), 'h01);
    sb_drain();

    // Asynchronous reset mid-frame.
    snap();
    send(8'h3C, 1'b1, 1'b0);
    wait_edges(4);
    #3;
    reset_n = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    tick();
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    check("post_reset_ready", 32'(o_ready),   1);
    check("post_reset_busy",  32'(o_busy),    0);
    check("post_reset_cs",    32'(o_load_cs), 0);
    sb_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
